// File: rtl/cfg_struct_arbiter_pkg.sv
// Shared types for the configuration-register arbiter: the cfg_t struct, its
// per-field write mask, reset default and FSM state encoding.
package cfg_arb_pkg;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } cfg_t;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } cfg_mask_t;

    parameter cfg_t CFG_DEFAULT = '{a: 1'b1, b: 1'b0, c: 1'b1, d: 1'b0};

    typedef enum logic {
        IDLE,
        SETTLE
    } arb_state_e;

endpackage

// File: rtl/cfg_struct_arbiter_if.sv
// Requester-side bus of cfg_struct_arbiter: valids, requested configs and grants.
// CFG_STRUCT_ARB_MASK_EN adds a per-requester field write mask.
interface cfg_struct_arbiter_if
    import cfg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]            req_valid_i;
    cfg_t [NUM_REQ-1:0]            req_cfg_i;
    logic [NUM_REQ-1:0]            req_ready_o;
`ifdef CFG_STRUCT_ARB_MASK_EN
    cfg_mask_t [NUM_REQ-1:0]       req_mask_i;

    modport master (output req_valid_i, output req_cfg_i, output req_mask_i, input req_ready_o);
    modport slave  (input req_valid_i, input req_cfg_i, input req_mask_i, output req_ready_o);
`else
    modport master (output req_valid_i, output req_cfg_i, input req_ready_o);
    modport slave  (input req_valid_i, input req_cfg_i, output req_ready_o);
`endif

endinterface

// File: rtl/cfg_struct_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after i_last, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        int unsigned j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(i_last) + k) % NUM_REQ;
            if (!o_any && i_valid[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cfg_struct_arbiter.sv
// Round-robin writer arbitration onto one cfg_t register with a post-commit settle
// blackout. CFG_STRUCT_ARB_MASK_EN enables per-field masked commits.
module cfg_struct_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 3,
    localparam int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    cfg_struct_arbiter_if.slave  arb_if,
    output cfg_t                 cfg_o,
    output logic                 cfg_changed_o,
    output logic                 busy_o,
    output logic [IDX_W-1:0]     last_grant_o
);

    localparam logic [3:0]       CNT_INIT  = 4'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_e         r_state;
    logic [3:0]         r_cnt;
    cfg_t               r_cfg;
    logic               r_changed;
    logic [IDX_W-1:0]   r_last;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    cfg_t               w_sel_cfg;
    cfg_t               w_new_cfg;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_valid (arb_if.req_valid_i),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_cfg = arb_if.req_cfg_i[w_idx];

`ifdef CFG_STRUCT_ARB_MASK_EN
    cfg_mask_t w_mask;
    assign w_mask = arb_if.req_mask_i[w_idx];

    always_comb begin
        w_new_cfg   = r_cfg;
        w_new_cfg.a = w_mask.a ? w_sel_cfg.a : r_cfg.a;
        w_new_cfg.b = w_mask.b ? w_sel_cfg.b : r_cfg.b;
        w_new_cfg.c = w_mask.c ? w_sel_cfg.c : r_cfg.c;
        w_new_cfg.d = w_mask.d ? w_sel_cfg.d : r_cfg.d;
    end
`else
    assign w_new_cfg = w_sel_cfg;
`endif

    // Grants only while IDLE; straight from live valids, so a withdrawn request never wins.
    assign arb_if.req_ready_o = (r_state == IDLE) ? w_grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cfg     <= CFG_DEFAULT;
            r_changed <= 1'b0;
            r_last    <= LAST_INIT;
        end else begin
            r_changed <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_cfg     <= w_new_cfg;
                        r_changed <= (w_new_cfg != r_cfg);
                        r_last    <= w_idx;
                        r_cnt     <= CNT_INIT;
                        r_state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cfg_o         = r_cfg;
    assign cfg_changed_o = r_changed;
    assign busy_o        = (r_state == SETTLE);
    assign last_grant_o  = r_last;

endmodule

// File: tb/tb_cfg_struct_arbiter.sv
// Scoreboard bench for cfg_struct_arbiter (NUM_REQ=4, SETTLE_CYCLES=3); the
// CFG_STRUCT_ARB_MASK_EN build adds masked-commit vectors.
module tb_cfg_struct_arbiter;
    import cfg_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int SETTLE  = 3;

    typedef struct {
        logic [3:0] ready;
        cfg_t       cfg;
        logic       chg;
        logic [1:0] last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    cfg_t       cfg_o;
    logic       cfg_changed_o;
    logic       busy_o;
    logic [1:0] last_grant_o;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_q[$];

    cfg_struct_arbiter_if #(.NUM_REQ(NUM_REQ)) arb_if ();

    cfg_struct_arbiter #(.NUM_REQ(NUM_REQ), .SETTLE_CYCLES(SETTLE)) dut (
        .clk           (clk),
        .rst           (rst),
        .arb_if        (arb_if),
        .cfg_o         (cfg_o),
        .cfg_changed_o (cfg_changed_o),
        .busy_o        (busy_o),
        .last_grant_o  (last_grant_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [3:0] c, input logic chg, input logic [1:0] l);
        exp_t e;
        e.ready = r;
        e.cfg   = cfg_t'(c);
        e.chg   = chg;
        e.last  = l;
        exp_q.push_back(e);
    endtask

    task automatic check_busy_window();
        for (int i = 0; i < SETTLE; i++) begin
            tick();
            check("busy_in_settle", 32'(busy_o), 32'd1);
        end
        tick();
        check("busy_after_settle", 32'(busy_o), 32'd0);
    endtask

    // Monitor: every grant seen must match the head of the queue, and the
    // following cycle must show the committed register state.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && arb_if.req_ready_o != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(arb_if.req_ready_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant", 32'(arb_if.req_ready_o), 32'(e.ready));
                    @(negedge clk);
                    check("cfg_o", 32'(cfg_o), 32'(e.cfg));
                    check("cfg_changed", 32'(cfg_changed_o), 32'(e.chg));
                    check("last_grant", 32'(last_grant_o), 32'(e.last));
                    check("busy_after_grant", 32'(busy_o), 32'd1);
                end
            end
        end
    end

    initial begin
        arb_if.req_valid_i = '0;
        arb_if.req_cfg_i   = '0;
`ifdef CFG_STRUCT_ARB_MASK_EN
        arb_if.req_mask_i  = '1;
`endif
        #12;
        check("rst_cfg", 32'(cfg_o), 32'hA);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_chg", 32'(cfg_changed_o), 32'd0);
        check("rst_last", 32'(last_grant_o), 32'd3);
        check("rst_ready", 32'(arb_if.req_ready_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single write from requester 2
        arb_if.req_cfg_i[2] = cfg_t'(4'b0101);
        arb_if.req_valid_i  = 4'b0100;
        push(4'b0100, 4'b0101, 1'b1, 2'd2);
        #1;
        check("single_ready_cycle0", 32'(arb_if.req_ready_o), 32'h4);
        @(posedge clk); #1;
        arb_if.req_valid_i = '0;
        check("busy_in_settle", 32'(busy_o), 32'd1);
        tick(); check("busy_in_settle", 32'(busy_o), 32'd1);
        tick(); check("busy_in_settle", 32'(busy_o), 32'd1);
        tick(); check("busy_after_settle", 32'(busy_o), 32'd0);

        // Asynchronous reset in the middle of a settle window
        arb_if.req_cfg_i[0] = cfg_t'(4'b1111);
        arb_if.req_valid_i  = 4'b0001;
        push(4'b0001, 4'b1111, 1'b1, 2'd0);
        tick();
        arb_if.req_valid_i = '0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_cfg", 32'(cfg_o), 32'hA);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_last", 32'(last_grant_o), 32'd3);
        tick();
        rst = 1'b0;
        tick();

        // Identical-value write: commit, no pulse
        arb_if.req_cfg_i[1] = cfg_t'(4'b1010);
        arb_if.req_valid_i  = 4'b0010;
        push(4'b0010, 4'b1010, 1'b0, 2'd1);
        @(posedge clk); #1;
        arb_if.req_valid_i = '0;
        check("ident_busy", 32'(busy_o), 32'd1);
        tick(); check("ident_busy", 32'(busy_o), 32'd1);
        tick(); check("ident_busy", 32'(busy_o), 32'd1);
        tick(); check("ident_busy_end", 32'(busy_o), 32'd0);

        // Request withdrawn during settle is never granted
        arb_if.req_cfg_i[0] = cfg_t'(4'b0011);
        arb_if.req_valid_i  = 4'b0001;
        push(4'b0001, 4'b0011, 1'b1, 2'd0);
        tick();
        arb_if.req_cfg_i[3] = cfg_t'(4'b1111);
        arb_if.req_valid_i  = 4'b1000;
        tick();
        arb_if.req_valid_i  = '0;
        tick(); tick(); tick();
        check("withdraw_cfg", 32'(cfg_o), 32'h3);
        check("withdraw_last", 32'(last_grant_o), 32'd0);
        check("withdraw_busy", 32'(busy_o), 32'd0);

        // All requesters valid: rotation 0,1,2,3,0 every SETTLE+1 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        arb_if.req_cfg_i[0] = cfg_t'(4'b0001);
        arb_if.req_cfg_i[1] = cfg_t'(4'b0010);
        arb_if.req_cfg_i[2] = cfg_t'(4'b0100);
        arb_if.req_cfg_i[3] = cfg_t'(4'b1000);
        push(4'b0001, 4'b0001, 1'b1, 2'd0);
        push(4'b0010, 4'b0010, 1'b1, 2'd1);
        push(4'b0100, 4'b0100, 1'b1, 2'd2);
        push(4'b1000, 4'b1000, 1'b1, 2'd3);
        push(4'b0001, 4'b0001, 1'b1, 2'd0);
        arb_if.req_valid_i = 4'b1111;
        for (int k = 0; k <= 16; k++) begin
            #1;
            check("rotation_grant_slot", 32'(arb_if.req_ready_o != '0), 32'((k % 4) == 0));
            @(posedge clk); #1;
        end
        arb_if.req_valid_i = '0;
        tick(); tick(); tick(); tick();

`ifdef CFG_STRUCT_ARB_MASK_EN
        // Masked commits, starting from the reset default 1010
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        arb_if.req_cfg_i[0]  = cfg_t'(4'b0101);
        arb_if.req_mask_i[0] = cfg_mask_t'(4'b1100);
        arb_if.req_valid_i   = 4'b0001;
        push(4'b0001, 4'b0110, 1'b1, 2'd0);
        tick();
        arb_if.req_valid_i = '0;
        check_busy_window();
        arb_if.req_cfg_i[1]  = cfg_t'(4'b1001);
        arb_if.req_mask_i[1] = cfg_mask_t'(4'b0000);
        arb_if.req_valid_i   = 4'b0010;
        push(4'b0010, 4'b0110, 1'b0, 2'd1);
        tick();
        arb_if.req_valid_i = '0;
        check_busy_window();
`endif

        tick(); tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cfg_struct_arbiter.md
Name: cfg_struct_arbiter

Overview:
- Round-robin arbiter that shares one packed-struct configuration register (fields a, b, c, d) between NUM_REQ requesters.
- The register resets to the package default pattern-assigned constant.
- After each accepted write, a settle window holds off further grants so the downstream datapath sees a stable configuration.
- Sits between software/control masters and the struct-consuming datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SETTLE_CYCLES, 3, cycles of grant blackout after each committed write (1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester write request.
- req_cfg_i  input  NUM_REQ x cfg_t  per-requester requested configuration.
- req_ready_o  output  NUM_REQ  one-hot grant/accept, combinational.
- cfg_o  output  cfg_t  current registered configuration.
- cfg_changed_o  output  1  one-cycle pulse, the cycle after a commit whose value differs from the old value.
- busy_o  output  1  high while in SETTLE.
- last_grant_o  output  $clog2(NUM_REQ)  index of the most recent granted requester.

Behaviour:
- Reset values: cfg_o = CFG_DEFAULT (a=1, b=0, c=1, d=0); cfg_changed_o = 0; busy_o = 0; last_grant_o = NUM_REQ-1, so requester 0 has first priority; state = IDLE.
- Reset is asynchronous and may arrive mid-SETTLE. It aborts the window and restores all reset values immediately. The settle counter is cleared.
- FSM IDLE:
  - If any req_valid_i is set, assert req_ready_o for the round-robin winner only.
  - The search starts at last_grant_o+1 and wraps modulo NUM_REQ.
  - At that edge: cfg_o <= winner's req_cfg_i; last_grant_o <= winner; counter <= SETTLE_CYCLES-1; go to SETTLE.
- FSM SETTLE:
  - req_ready_o = 0 and busy_o = 1.
  - Counter decrements each cycle. Return to IDLE on the edge where the counter is 0.
  - A requester can be granted again exactly SETTLE_CYCLES+1 cycles after its previous grant.
- No grant when there are no valids. The pointer is unchanged while idle.
- Requesters must hold valid and cfg until ready.
- Dropping valid without ready is allowed (no commit). The ready computation does not depend on stale state.
- cfg_changed_o compares the new value against the old cfg_o as whole-struct inequality. A commit of an identical value updates last_grant_o and still enters SETTLE, but does not pulse.
- Latency: request to cfg_o update is 1 cycle when IDLE and the requester wins.
- All-requesters-valid case: grants rotate 0,1,2,3,0,… with one grant per SETTLE_CYCLES+1 cycles.
- Struct fields are accessed by name only. No positional bit slicing.

Optional Feature:
- Macro: CFG_STRUCT_ARB_MASK_EN.
- When defined:
  - Adds input req_mask_i, NUM_REQ x cfg_mask_t (one bit per field a..d).
  - A commit updates only the fields whose mask bit is 1. Other fields retain their old value.
  - An all-zero mask is still granted, commits nothing, and enters SETTLE.
  - cfg_changed_o reflects the actual post-mask difference.
- When undefined: the port is absent and every commit writes the whole struct.

Decomposition:
- Package cfg_arb_pkg holds:
  - typedef struct packed cfg_t {logic a, b, c, d}.
  - typedef struct packed cfg_mask_t with the same field names.
  - parameter cfg_t CFG_DEFAULT = '{a:1'b1, b:1'b0, c:1'b1, d:1'b0}, assigned by field-name pattern.
  - typedef enum logic {IDLE, SETTLE} arb_state_e.
- Sub-module rr_pick: combinational round-robin one-hot picker.
  - Inputs: valid vector, last index.
  - Outputs: one-hot grant, index, any.
  - Instantiated once.

Test Plan:
- Reset release: cfg_o = 4'b1010 (a..d = 1,0,1,0), busy_o = 0, no ready; assert rst mid-SETTLE → cfg_o returns to 1010 asynchronously and busy_o = 0.
- Single write, SETTLE_CYCLES = 3: req 2 valid with cfg {0,1,0,1} at cycle 0 → ready[2] at cycle 0; cfg_o = 0101 and cfg_changed_o = 1 at cycle 1; busy_o high for cycles 1-3; next grant possible at cycle 4.
- All four valid continuously → grant order 0,1,2,3,0 at cycles 0,4,8,12,16.
- Identical-value write: req 1 writes 1010 from reset → grant, last_grant_o = 1, cfg_changed_o stays 0, busy_o high for 3 cycles.
- Mask (with CFG_STRUCT_ARB_MASK_EN): from 1010, req 0 writes cfg 0101 with mask a=1, b=1, c=0, d=0 → cfg_o = 0110 and cfg_changed_o pulses; a zero mask → cfg_o unchanged, no pulse, SETTLE entered.
- Valid withdrawn during SETTLE: req 3 asserts then drops before IDLE → no grant to 3, cfg_o unchanged, pointer unchanged.
